// File: rtl/ifetch_pkg.sv
// ifetch_pkg
// Shared definitions for the instruction-fetch responder: FSM state
// encoding, response tags, the mandatory fetch byte-select pattern and a
// saturating counter helper.
package ifetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   localparam logic [3:0] ITAG_NI   = 4'h0;
   localparam logic [3:0] ITAG_BE   = 4'hB;
   localparam logic [3:0] FETCH_SEL = 4'hF;

   // Holds at all-ones instead of wrapping back to zero.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/ifetch_mem.sv
// ifetch_mem
// Instruction array: one write port for bench preload, one registered read
// port. A read and a write to the same word on the same edge returns the
// old contents. Contents are not reset.
// Ports:
//   clk   clock
//   we    preload write strobe
//   wadr  preload word address
//   wdat  preload data
//   re    read enable (read data registered on this edge)
//   radr  read word address
//   rdat  registered read data
module ifetch_mem #(
   parameter int MEM_AW = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [MEM_AW-1:0] wadr,
   input  logic [31:0]       wdat,
   input  logic              re,
   input  logic [MEM_AW-1:0] radr,
   output logic [31:0]       rdat
);

   logic [31:0] mem [0:(1<<MEM_AW)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wadr] <= wdat;
      end
      if (re) begin
         rdat <= mem[radr];
      end
   end

endmodule

// File: rtl/ifetch_sva.sv
// ifetch_sva
// Protocol checker bound into every ifetch_responder instance. Checks that
// ack/err never coincide, that ack always carries the normal tag, that a
// response only follows an outstanding request, and that the response
// arrives WAIT_STATES+1 cycles after the most recent accept or redirect.
// Ports: clk/rst plus read-only views of the responder's bus signals,
// its FSM state and latched request address.
module ifetch_sva
   import ifetch_pkg::*;
#(
   parameter int WAIT_STATES = 2
) (
   input logic        clk,
   input logic        rst,
   input logic        cycstb,
   input logic [31:0] adr,
   input logic        ack,
   input logic        err,
   input logic [3:0]  tag,
   input state_t      state,
   input logic [31:0] req_adr
);

   localparam logic [4:0] LAT = 5'(WAIT_STATES + 1);

   logic       accept_evt;
   logic [4:0] since;
   logic       pending;

   assign accept_evt = cycstb &&
                       ((state == IDLE) || ((state == WAIT) && (adr != req_adr)));

   // Cycles since the last accept/redirect, and whether a request is open.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         since   <= 5'd0;
         pending <= 1'b0;
      end else begin
         if (accept_evt) begin
            since <= 5'd1;
         end else if (since != 5'h1F) begin
            since <= since + 5'd1;
         end
         if (accept_evt) begin
            pending <= 1'b1;
         end else if (((state == WAIT) && !cycstb) || ack || err) begin
            pending <= 1'b0;
         end
      end
   end

   a_mutex:   assert property (@(posedge clk) disable iff (!rst) !(ack && err));
   a_ack_tag: assert property (@(posedge clk) disable iff (!rst) ack |-> (tag == ITAG_NI));
   a_pending: assert property (@(posedge clk) disable iff (!rst) (ack || err) |-> pending);
   a_latency: assert property (@(posedge clk) disable iff (!rst) (ack || err) |-> (since == LAT));

endmodule

bind ifetch_responder ifetch_sva #(.WAIT_STATES(WAIT_STATES)) u_ifetch_sva (
   .clk     (clk),
   .rst     (rst),
   .cycstb  (icpu_cycstb_i),
   .adr     (icpu_adr_i),
   .ack     (icpu_ack_o),
   .err     (icpu_err_o),
   .tag     (icpu_tag_o),
   .state   (state),
   .req_adr (req_adr)
);

// File: rtl/ifetch_responder.sv
// ifetch_responder
// Instruction-bus responder for the or1200 fetch path. Accepts a fetch,
// waits WAIT_STATES cycles, then returns one ack (with the instruction
// word) or one err (bus-error tag). A dropped request or a changed address
// during the wait aborts/restarts the fetch and bumps abort_cnt_o.
// Ports:
//   clk, rst (async, active-low)
//   icpu_cycstb_i/adr_i/sel_i   fetch request
//   icpu_ack_o/err_o/dat_o/tag_o  registered one-cycle response
//   ld_we_i/ld_adr_i/ld_dat_i   instruction array preload
//   abort_cnt_o                 saturating abort/redirect count
module ifetch_responder
   import ifetch_pkg::*;
#(
   parameter int          MEM_AW      = 10,
   parameter int          WAIT_STATES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              icpu_cycstb_i,
   input  logic [31:0]       icpu_adr_i,
   input  logic [3:0]        icpu_sel_i,
   output logic              icpu_ack_o,
   output logic              icpu_err_o,
   output logic [31:0]       icpu_dat_o,
   output logic [3:0]        icpu_tag_o,
   input  logic              ld_we_i,
   input  logic [MEM_AW-1:0] ld_adr_i,
   input  logic [31:0]       ld_dat_i,
   output logic [15:0]       abort_cnt_o
);

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] req_adr;
   logic        ack_q;
   logic        err_q;
   logic [3:0]  tag_q;
   logic [15:0] abort_cnt;
   logic [31:0] offset;
   logic        bad_req;
   logic        go_resp;
   logic [31:0] mem_rdat;

   // On the RESP-entry edge the live address always equals req_adr (either
   // just latched with zero wait states, or compared equal), so decode it.
   // BASE_ADDR is word aligned, hence offset[1:0] mirrors adr[1:0]; the
   // subtraction wraps, so addresses below BASE_ADDR fall out of range.
   assign offset  = icpu_adr_i - BASE_ADDR;
   assign bad_req = (offset[1:0] != 2'b00) ||
                    (icpu_sel_i != FETCH_SEL) ||
                    (offset[31:MEM_AW+2] != '0);

   always_comb begin
      go_resp = 1'b0;
      case (state)
         IDLE:    go_resp = icpu_cycstb_i && (WAIT_STATES == 0);
         WAIT:    go_resp = icpu_cycstb_i && (icpu_adr_i == req_adr) && (cnt == 4'd1);
         default: go_resp = 1'b0;
      endcase
   end

   ifetch_mem #(.MEM_AW(MEM_AW)) u_mem (
      .clk  (clk),
      .we   (ld_we_i),
      .wadr (ld_adr_i),
      .wdat (ld_dat_i),
      .re   (go_resp),
      .radr (offset[MEM_AW+1:2]),
      .rdat (mem_rdat)
   );

   // Response flags default low every cycle so RESP lasts exactly one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         req_adr   <= 32'h0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         tag_q     <= ITAG_NI;
         abort_cnt <= 16'h0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         tag_q <= ITAG_NI;
         case (state)
            IDLE: begin
               if (icpu_cycstb_i) begin
                  req_adr <= icpu_adr_i;
                  cnt     <= 4'(WAIT_STATES);
                  state   <= (WAIT_STATES == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (!icpu_cycstb_i) begin
                  state     <= IDLE;
                  abort_cnt <= sat_inc16(abort_cnt);
               end else if (icpu_adr_i != req_adr) begin
                  req_adr   <= icpu_adr_i;
                  cnt       <= 4'(WAIT_STATES);
                  abort_cnt <= sat_inc16(abort_cnt);
               end else begin
                  cnt <= cnt - 4'd1;
                  if (cnt == 4'd1) begin
                     state <= RESP;
                  end
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
         if (go_resp) begin
            ack_q <= !bad_req;
            err_q <= bad_req;
            tag_q <= bad_req ? ITAG_BE : ITAG_NI;
         end
      end
   end

   assign icpu_ack_o  = ack_q;
   assign icpu_err_o  = err_q;
   assign icpu_tag_o  = tag_q;
   assign icpu_dat_o  = ack_q ? mem_rdat : 32'h0;
   assign abort_cnt_o = abort_cnt;

endmodule

// File: tb/tb_ifetch_responder.sv
// tb_ifetch_responder
// Directed bench for ifetch_responder (WAIT_STATES=2 main instance plus a
// WAIT_STATES=0 instance). Expected responses are queued when a request is
// driven and popped by a monitor when the responder answers.
module tb_ifetch_responder;

   localparam int MEM_AW = 10;
   localparam int WS     = 2;

   typedef struct packed {
      logic        err;
      logic [31:0] dat;
      logic [3:0]  tag;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              cycstb, cycstb0;
   logic [31:0]       adr, adr0;
   logic [3:0]        sel, sel0;
   logic              ack, err, ack0, err0;
   logic [31:0]       dat, dat0;
   logic [3:0]        tag, tag0;
   logic              ld_we;
   logic [MEM_AW-1:0] ld_adr;
   logic [31:0]       ld_dat;
   logic [15:0]       abort_cnt, abort_cnt0;

   exp_t        sb_q[$];
   exp_t        mon_e;
   logic [31:0] shadow [0:(1<<MEM_AW)-1];
   int          compared   = 0;
   int          mismatched = 0;

   always #5 clk = ~clk;

   ifetch_responder #(.MEM_AW(MEM_AW), .WAIT_STATES(WS), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst(rst),
      .icpu_cycstb_i(cycstb), .icpu_adr_i(adr), .icpu_sel_i(sel),
      .icpu_ack_o(ack), .icpu_err_o(err), .icpu_dat_o(dat), .icpu_tag_o(tag),
      .ld_we_i(ld_we), .ld_adr_i(ld_adr), .ld_dat_i(ld_dat),
      .abort_cnt_o(abort_cnt)
   );

   ifetch_responder #(.MEM_AW(MEM_AW), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut_ws0 (
      .clk(clk), .rst(rst),
      .icpu_cycstb_i(cycstb0), .icpu_adr_i(adr0), .icpu_sel_i(sel0),
      .icpu_ack_o(ack0), .icpu_err_o(err0), .icpu_dat_o(dat0), .icpu_tag_o(tag0),
      .ld_we_i(ld_we), .ld_adr_i(ld_adr), .ld_dat_i(ld_dat),
      .abort_cnt_o(abort_cnt0)
   );

   task automatic check_output(input string name, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
      end
   endtask

   // Independent reference: aligned, full select, within the 4 KiB array.
   task automatic apply_stimulus(input logic [31:0] a, input logic [3:0] s);
      exp_t e;
      logic bad;
      bad   = (a[1:0] != 2'b00) || (s != 4'hF) || (a >= 32'h0000_1000);
      e.err = bad;
      e.dat = bad ? 32'h0 : shadow[a[11:2]];
      e.tag = bad ? 4'hB : 4'h0;
      sb_q.push_back(e);
      cycstb = 1'b1;
      adr    = a;
      sel    = s;
   endtask

   task automatic wait_response(input string name, input int exp_k);
      int k;
      bit seen;
      k    = 0;
      seen = 1'b0;
      while (!seen && k < 20) begin
         @(negedge clk);
         k++;
         seen = ack || err;
      end
      if (!seen) k = 99;
      check_output(name, k, exp_k);
   endtask

   task automatic idle_bus();
      cycstb = 1'b0;
      adr    = 32'h0;
      sel    = 4'hF;
   endtask

   task automatic load_word(input int w, input logic [31:0] d);
      @(negedge clk);
      ld_we  = 1'b1;
      ld_adr = w[MEM_AW-1:0];
      ld_dat = d;
      @(negedge clk);
      ld_we  = 1'b0;
      shadow[w] = d;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rst && (ack || err)) begin
         if (sb_q.size() == 0) begin
            check_output("unexpected_response", {30'h0, err, ack}, 32'h0);
         end else begin
            mon_e = sb_q.pop_front();
            check_output("resp_ack", {31'h0, ack}, {31'h0, !mon_e.err});
            check_output("resp_err", {31'h0, err}, {31'h0, mon_e.err});
            check_output("resp_dat", dat, mon_e.dat);
            check_output("resp_tag", {28'h0, tag}, {28'h0, mon_e.tag});
         end
      end
   end

   initial begin
      cycstb  = 1'b0; adr  = 32'h0; sel  = 4'hF;
      cycstb0 = 1'b0; adr0 = 32'h0; sel0 = 4'hF;
      ld_we   = 1'b0; ld_adr = '0; ld_dat = 32'h0;

      // Reset state
      #12;
      check_output("rst_ack", {31'h0, ack}, 32'h0);
      check_output("rst_err", {31'h0, err}, 32'h0);
      check_output("rst_dat", dat, 32'h0);
      check_output("rst_tag", {28'h0, tag}, 32'h0);
      check_output("rst_abort", {16'h0, abort_cnt}, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      load_word(0,    32'h1500_0000);
      load_word(1,    32'h1500_0004);
      load_word(2,    32'h1500_0008);
      load_word(4,    32'h1500_0010);
      load_word(8,    32'h1500_0020);
      load_word(12,   32'h1500_0030);
      load_word(64,   32'h1500_0100);
      load_word(1023, 32'h1500_0FFC);

      // Single fetch: ack three cycles after accept, idle the cycle after
      @(negedge clk);
      apply_stimulus(32'h0, 4'hF);
      wait_response("single_lat", WS + 1);
      idle_bus();
      @(negedge clk);
      check_output("idle_ack", {31'h0, ack}, 32'h0);
      check_output("idle_err", {31'h0, err}, 32'h0);
      check_output("idle_dat", dat, 32'h0);
      check_output("idle_tag", {28'h0, tag}, 32'h0);

      // Back-to-back with cycstb held: one fetch every WS+2 cycles
      apply_stimulus(32'h0, 4'hF);
      wait_response("b2b0_lat", WS + 1);
      apply_stimulus(32'h4, 4'hF);
      wait_response("b2b1_lat", WS + 2);
      apply_stimulus(32'h8, 4'hF);
      wait_response("b2b2_lat", WS + 2);
      idle_bus();
      check_output("b2b_abort", {16'h0, abort_cnt}, 32'h0);

      // Abort: request dropped during the wait
      @(negedge clk);
      cycstb = 1'b1; adr = 32'h20;
      @(negedge clk);
      cycstb = 1'b0;
      @(negedge clk);
      check_output("abort_cnt", {16'h0, abort_cnt}, 32'h1);
      repeat (4) @(negedge clk);
      apply_stimulus(32'h20, 4'hF);
      wait_response("after_abort_lat", WS + 1);
      idle_bus();

      // Redirect in the final wait cycle restarts the wait
      do_reset();
      @(negedge clk);
      cycstb = 1'b1; adr = 32'h10;
      @(negedge clk);
      @(negedge clk);
      apply_stimulus(32'h100, 4'hF);
      wait_response("redirect_lat", WS + 1);
      idle_bus();
      check_output("redirect_abort", {16'h0, abort_cnt}, 32'h1);

      // Asynchronous reset in the middle of a wait
      @(negedge clk);
      cycstb = 1'b1; adr = 32'h8;
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check_output("async_rst_abort", {16'h0, abort_cnt}, 32'h0);
      check_output("async_rst_ack", {31'h0, ack}, 32'h0);
      @(negedge clk);
      idle_bus();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      apply_stimulus(32'h4, 4'hF);
      wait_response("post_rst_lat", WS + 1);
      idle_bus();

      // Error responses and the last in-range word
      @(negedge clk);
      apply_stimulus(32'h1000, 4'hF);
      wait_response("err_range_lat", WS + 1);
      idle_bus();
      @(negedge clk);
      apply_stimulus(32'h2, 4'hF);
      wait_response("err_align_lat", WS + 1);
      idle_bus();
      @(negedge clk);
      apply_stimulus(32'h0, 4'h3);
      wait_response("err_sel_lat", WS + 1);
      idle_bus();
      @(negedge clk);
      apply_stimulus(32'hFFC, 4'hF);
      wait_response("top_word_lat", WS + 1);
      idle_bus();

      // Preload write on the RESP-entry edge: old word is returned
      @(negedge clk);
      apply_stimulus(32'h30, 4'hF);
      @(negedge clk);
      @(negedge clk);
      ld_we = 1'b1; ld_adr = 10'd12; ld_dat = 32'hDEAD_0030;
      wait_response("rbw_lat", 1);
      ld_we = 1'b0;
      shadow[12] = 32'hDEAD_0030;
      idle_bus();
      @(negedge clk);
      apply_stimulus(32'h30, 4'hF);
      wait_response("rbw_new_lat", WS + 1);
      idle_bus();

      // Zero wait states: response one cycle after accept
      @(negedge clk);
      cycstb0 = 1'b1; adr0 = 32'h0; sel0 = 4'hF;
      @(negedge clk);
      cycstb0 = 1'b0;
      check_output("ws0_ack", {31'h0, ack0}, 32'h1);
      check_output("ws0_dat", dat0, shadow[0]);
      check_output("ws0_tag", {28'h0, tag0}, 32'h0);
      @(negedge clk);
      check_output("ws0_idle_ack", {31'h0, ack0}, 32'h0);
      cycstb0 = 1'b1; adr0 = 32'h3;
      @(negedge clk);
      cycstb0 = 1'b0;
      check_output("ws0_err", {31'h0, err0}, 32'h1);
      check_output("ws0_err_tag", {28'h0, tag0}, 32'hB);
      check_output("ws0_err_dat", dat0, 32'h0);
      check_output("ws0_abort", {16'h0, abort_cnt0}, 32'h0);

      repeat (3) @(negedge clk);
      check_output("sb_drained", sb_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ifetch_responder.md
Name: ifetch_responder

Overview:
- Instruction-bus responder (slave) for the or1200 fetch path. It is the other end of the address stream produced by the PC generator, seen through the icpu interface.
- Accepts fetch requests (cycstb/adr/sel), inserts programmable wait states, and returns the instruction word with ack, or returns err with bus-error tag.
- Handles fetch redirects: request dropped, or address changed mid-wait, on branch/exception/spr_pc_we.
- Includes a bench-loadable instruction array; used as the fetch-side model in formal and simulation benches.

Parameters:
- MEM_AW, 10, word-address bits of the instruction array (depth 2^MEM_AW words)
- WAIT_STATES, 2, idle cycles between request acceptance and response (0..15)
- BASE_ADDR, 32'h0000_0000, byte address of array word 0 (must be 4-byte aligned)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- icpu_cycstb_i  in  1  fetch request valid
- icpu_adr_i  in  32  fetch byte address
- icpu_sel_i  in  4  byte selects (must be 4'hF for fetch)
- icpu_ack_o  out  1  one-cycle response-valid pulse
- icpu_err_o  out  1  one-cycle bus-error pulse
- icpu_dat_o  out  32  instruction word, valid only with ack
- icpu_tag_o  out  4  4'h0 normal (ITAG_NI), 4'hB bus error (ITAG_BE)
- ld_we_i  in  1  preload write strobe
- ld_adr_i  in  MEM_AW  preload word address
- ld_dat_i  in  32  preload data
- abort_cnt_o  out  16  saturating count of aborted/redirected requests

Behaviour:
- Reset (rst=0, async): state IDLE; ack=0, err=0, dat=0, tag=4'h0, wait counter=0, abort_cnt=0. Array contents are not reset.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE -> WAIT when cycstb=1. On that edge, latch adr into req_adr and load cnt=WAIT_STATES. If WAIT_STATES=0, go directly to RESP.
- WAIT: cnt decrements each cycle. At cnt==1 with cycstb=1 and adr==req_adr, go to RESP.
- RESP is a single cycle. Exactly one of ack or err is 1 in it, then the FSM returns to IDLE.
- Latency: the response pulse occurs WAIT_STATES+1 cycles after the accept edge. Throughput is one fetch per WAIT_STATES+2 cycles, because the next request is sampled in IDLE in the cycle after RESP.
- Abort: in WAIT, cycstb=0 sends the FSM to IDLE with no response, and abort_cnt increments.
- Redirect: in WAIT, cycstb=1 with adr!=req_adr relatches adr, reloads cnt=WAIT_STATES, stays in WAIT, and increments abort_cnt. A redirect in the final wait cycle also restarts; no stale ack is ever produced.
- Error conditions, evaluated on req_adr at the RESP transition:
  - adr[1:0]!=0, or
  - sel!=4'hF, or
  - (req_adr-BASE_ADDR)>>2 >= 2^MEM_AW (unsigned, 32-bit wrap counts as out of range).
  - Result: err=1, ack=0, tag=4'hB, dat=0.
- Normal response: ack=1, tag=4'h0, dat=array[(req_adr-BASE_ADDR)>>2]. Outside RESP, ack=err=0, dat=0, tag=0.
- Preload: ld_we writes array on the clock edge. The read is registered on the edge entering RESP; a same-edge write to the same word returns the old data (read-before-write).
- cycstb dropping during the RESP cycle is ignored; the response is already committed.
- abort_cnt saturates at 16'hFFFF.
- Reset asserted mid-request clears all state immediately. The first fetch after release is accepted in IDLE.

Decomposition:
- Shared package ifetch_pkg holds:
  - state enum (IDLE, WAIT, RESP)
  - ITAG_NI=4'h0, ITAG_BE=4'hB
  - FETCH_SEL=4'hF
- Sub-module ifetch_mem: single-port-write, registered-read array (MEM_AW × 32), instantiated once.
- Companion SVA module bound to ifetch_responder. It checks:
  - ack and err are mutually exclusive
  - ack implies tag=0
  - no response without a pending request
  - latency equals WAIT_STATES+1 absent redirect

Test Plan:
- WAIT_STATES=2, preload word 0=32'h1500_0000; cycstb=1 with adr=0 at cycle 0 -> ack=1, dat=32'h1500_0000, tag=0 at cycle 3; idle at cycle 4.
- Back-to-back fetches adr=0x0, 0x4, 0x8 with cycstb held -> acks at cycles 3, 7, 11 with the matching words; abort_cnt stays 0.
- Redirect: accept adr=0x10, then change adr to 0x100 at cycle 2 -> no ack for 0x10; ack for 0x100 at cycle 5; abort_cnt=1.
- Abort: accept adr=0x20, drop cycstb at cycle 1 -> no ack/err ever; FSM in IDLE at cycle 2; abort_cnt=1.
- Error, MEM_AW=10: adr=0x1000 -> err=1, tag=4'hB, dat=0 at cycle 3. Repeat with adr=0x2 and with sel=4'h3 -> same err response.
- Reset mid-WAIT: rst=0 at cycle 1 -> outputs 0 asynchronously. Release; new request adr=0x4 -> ack WAIT_STATES+1 cycles after accept. Also run WAIT_STATES=0: ack on cycle 1.
